// File: rtl/quantum_state_magnitudes_seq.sv
// quantum_state_magnitudes_seq
//   Sequential |a_k|^2 engine for a 2**NUM_QUBITS amplitude state vector.
//   One amplitude per cycle through a single pair of squarers; results are
//   streamed (mag_valid/mag_index/mag_sq) and collected into mag_vec_out.
//   Optional feature macro: ARGMAX_EN (running argmax on max_index/max_mag).
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready=1, waiting for start; outputs hold last results
//   CALC  | squaring amplitude idx, result registered for next cycle
`ifndef TOTAL_BITS
`define TOTAL_BITS 16
`endif
`ifndef FX_BITS
`define FX_BITS 8
`endif

module quantum_state_magnitudes_seq #(
   parameter int NUM_QUBITS = 2,
   parameter int W          = `TOTAL_BITS,
   parameter int FRAC       = `FX_BITS
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic [2*W*(1 << NUM_QUBITS)-1:0]      q_state_in,
   output logic                                  ready,
   output logic                                  mag_valid,
   output logic [NUM_QUBITS-1:0]                 mag_index,
   output logic [W-1:0]                          mag_sq,
   output logic [W*(1 << NUM_QUBITS)-1:0]        mag_vec_out,
   output logic                                  done,
   output logic [NUM_QUBITS-1:0]                 max_index,
   output logic [W-1:0]                          max_mag
);

   localparam int N = 1 << NUM_QUBITS;
   localparam logic [NUM_QUBITS-1:0] LAST = NUM_QUBITS'(N - 1);
   localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [2*W-1:0] MAXV_WIDE = {{W{1'b0}}, MAXV};

   typedef enum logic {IDLE, CALC} state_t;

   state_t                  state, state_nxt;
   logic                    accept;
   logic [2*W*N-1:0]        q_reg;
   logic [NUM_QUBITS-1:0]   idx;
   logic [2*W-1:0]          amp_cur;
   logic [W-1:0]            re_sq, im_sq, mag_cur;
   logic [W:0]              mag_sum;

   // Square of a signed fixed-point value, rescaled by FRAC and clipped to the
   // positive range; -2^(W-1) squares to a value that always clips.
   function automatic logic [W-1:0] sq_sat(input logic [W-1:0] x);
      logic signed [2*W-1:0] xe;
      logic signed [2*W-1:0] p;
      xe = {{W{x[W-1]}}, x};
      p  = (xe * xe) >>> FRAC;
      if (p > MAXV_WIDE) return MAXV;
      return p[W-1:0];
   endfunction

   assign ready   = (state == IDLE);
   assign amp_cur = q_reg[(N - 1 - int'(idx))*2*W +: 2*W];

   // Magnitude of the amplitude currently selected by idx
   always_comb begin
      re_sq   = sq_sat(amp_cur[2*W-1 -: W]);
      im_sq   = sq_sat(amp_cur[W-1:0]);
      mag_sum = {1'b0, re_sq} + {1'b0, im_sq};
      mag_cur = (mag_sum > {1'b0, MAXV}) ? MAXV : mag_sum[W-1:0];
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and start acceptance
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: if (start) begin
            accept    = 1'b1;
            state_nxt = CALC;
         end
         CALC: if (idx == LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Capture, index counter and registered result stream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg       <= '0;
         idx         <= '0;
         mag_valid   <= 1'b0;
         mag_index   <= '0;
         mag_sq      <= '0;
         mag_vec_out <= '0;
         done        <= 1'b0;
      end else begin
         mag_valid <= 1'b0;
         done      <= 1'b0;
         if (accept) begin
            q_reg <= q_state_in;
            idx   <= '0;
         end
         if (state == CALC) begin
            mag_valid <= 1'b1;
            mag_index <= idx;
            mag_sq    <= mag_cur;
            mag_vec_out[(N - 1 - int'(idx))*W +: W] <= mag_cur;
            done      <= (idx == LAST);
            idx       <= idx + NUM_QUBITS'(1);
         end
      end
   end

`ifdef ARGMAX_EN
   // Running argmax; strict compare keeps the lowest index on ties
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_index <= '0;
         max_mag   <= '0;
      end else if (accept) begin
         max_index <= '0;
         max_mag   <= '0;
      end else if (state == CALC && mag_cur > max_mag) begin
         max_index <= idx;
         max_mag   <= mag_cur;
      end
   end
`else
   assign max_index = '0;
   assign max_mag   = '0;
`endif

endmodule

// File: tb/tb_quantum_state_magnitudes_seq.sv
// Directed bench for quantum_state_magnitudes_seq (NUM_QUBITS=2, W=16, FRAC=8).
// Cycle 0 is the cycle in which start is presented; outputs are sampled on
// the falling edge of each cycle.
module tb_quantum_state_magnitudes_seq;

   localparam int NQ = 2;
   localparam int W  = 16;
   localparam int N  = 4;

   localparam logic [127:0] V_UNI = {4{16'h0080, 16'h0000}};
   localparam logic [127:0] V_MIX = {16'hFF80, 16'h0080, 96'h0};
   localparam logic [127:0] V_SAT = {32'h0, 32'h0, 32'h7FFF_7FFF, 32'h8000_0000};

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [127:0]   q_state_in = '0;
   logic           ready, mag_valid, done;
   logic [NQ-1:0]  mag_index, max_index;
   logic [W-1:0]   mag_sq, max_mag;
   logic [63:0]    mag_vec_out;

   int errors = 0;
   int checks = 0;

   logic           o_valid [0:15];
   logic [NQ-1:0]  o_idx   [0:15];
   logic [W-1:0]   o_sq    [0:15];
   logic           o_done  [0:15];
   logic           o_ready [0:15];
   logic [63:0]    o_vec   [0:15];
   logic [NQ-1:0]  o_maxi  [0:15];
   logic [W-1:0]   o_maxm  [0:15];

   quantum_state_magnitudes_seq #(.NUM_QUBITS(NQ), .W(W), .FRAC(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .q_state_in(q_state_in),
      .ready(ready), .mag_valid(mag_valid), .mag_index(mag_index), .mag_sq(mag_sq),
      .mag_vec_out(mag_vec_out), .done(done), .max_index(max_index), .max_mag(max_mag)
   );

   always #5 clk = ~clk;

   // Records outputs for cycles 0..ncyc-1; start is high in cycles 0..hold-1,
   // q_state_in is v0 in cycle 0 and v1 afterwards.
   task automatic capture(input logic [127:0] v0, input logic [127:0] v1,
                          input int hold, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         o_valid[c] = mag_valid;  o_idx[c]   = mag_index;  o_sq[c]   = mag_sq;
         o_done[c]  = done;       o_ready[c] = ready;      o_vec[c]  = mag_vec_out;
         o_maxi[c]  = max_index;  o_maxm[c]  = max_mag;
         start      = (c < hold);
         q_state_in = (c == 0) ? v0 : v1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks += 8;
      if (ready !== 1'b1)         begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
      if (mag_valid !== 1'b0)     begin errors++; $display("FAIL reset_valid got %b want 0", mag_valid); end
      if (done !== 1'b0)          begin errors++; $display("FAIL reset_done got %b want 0", done); end
      if (mag_index !== 2'd0)     begin errors++; $display("FAIL reset_index got %0d want 0", mag_index); end
      if (mag_sq !== 16'h0)       begin errors++; $display("FAIL reset_sq got %h want 0000", mag_sq); end
      if (mag_vec_out !== 64'h0)  begin errors++; $display("FAIL reset_vec got %h want 0", mag_vec_out); end
      if (max_index !== 2'd0)     begin errors++; $display("FAIL reset_maxi got %0d want 0", max_index); end
      if (max_mag !== 16'h0)      begin errors++; $display("FAIL reset_maxm got %h want 0000", max_mag); end
      rst_n = 1'b1;
   endtask

   task automatic test_uniform;
      logic exp_v;
      capture(V_UNI, V_UNI, 1, 8);
      for (int c = 0; c < 8; c++) begin
         exp_v = (c >= 2 && c <= 5);
         checks += 3;
         if (o_valid[c] !== exp_v) begin errors++; $display("FAIL uni_valid c%0d got %b want %b", c, o_valid[c], exp_v); end
         if (o_done[c] !== (c == 5)) begin errors++; $display("FAIL uni_done c%0d got %b want %b", c, o_done[c], (c == 5)); end
         if (o_ready[c] !== (c == 0 || c >= 5)) begin errors++; $display("FAIL uni_ready c%0d got %b", c, o_ready[c]); end
         if (exp_v) begin
            checks += 2;
            if (o_idx[c] !== 2'(c - 2)) begin errors++; $display("FAIL uni_index c%0d got %0d want %0d", c, o_idx[c], c - 2); end
            if (o_sq[c] !== 16'h0040)   begin errors++; $display("FAIL uni_sq c%0d got %h want 0040", c, o_sq[c]); end
         end
      end
      checks += 2;
      if (o_vec[3] !== 64'h0040_0040_0000_0000) begin errors++; $display("FAIL uni_vec_partial got %h want 0040004000000000", o_vec[3]); end
      if (o_vec[5] !== 64'h0040_0040_0040_0040) begin errors++; $display("FAIL uni_vec got %h want 0040004000400040", o_vec[5]); end
`ifdef ARGMAX_EN
      checks += 2;
      if (o_maxi[5] !== 2'd0)     begin errors++; $display("FAIL uni_maxi got %0d want 0", o_maxi[5]); end
      if (o_maxm[5] !== 16'h0040) begin errors++; $display("FAIL uni_maxm got %h want 0040", o_maxm[5]); end
`else
      checks += 2;
      if (o_maxi[5] !== 2'd0)     begin errors++; $display("FAIL uni_maxi got %0d want 0", o_maxi[5]); end
      if (o_maxm[5] !== 16'h0000) begin errors++; $display("FAIL uni_maxm got %h want 0000", o_maxm[5]); end
`endif
   endtask

   task automatic test_mixed_signs;
      logic [W-1:0] exp_sq [0:3];
      exp_sq = '{16'h0080, 16'h0000, 16'h0000, 16'h0000};
      capture(V_MIX, V_MIX, 1, 8);
      for (int c = 2; c <= 5; c++) begin
         checks += 3;
         if (o_valid[c] !== 1'b1)          begin errors++; $display("FAIL mix_valid c%0d got %b want 1", c, o_valid[c]); end
         if (o_idx[c] !== 2'(c - 2))       begin errors++; $display("FAIL mix_index c%0d got %0d want %0d", c, o_idx[c], c - 2); end
         if (o_sq[c] !== exp_sq[c - 2])    begin errors++; $display("FAIL mix_sq c%0d got %h want %h", c, o_sq[c], exp_sq[c - 2]); end
      end
      checks += 3;
      if (o_vec[3] !== 64'h0080_0000_0040_0040) begin errors++; $display("FAIL mix_vec_partial got %h want 0080000000400040", o_vec[3]); end
      if (o_vec[5] !== 64'h0080_0000_0000_0000) begin errors++; $display("FAIL mix_vec got %h want 0080000000000000", o_vec[5]); end
      if (o_valid[6] !== 1'b0) begin errors++; $display("FAIL mix_valid_after got %b want 0", o_valid[6]); end
`ifdef ARGMAX_EN
      checks += 3;
      if (o_maxi[5] !== 2'd0)     begin errors++; $display("FAIL mix_maxi got %0d want 0", o_maxi[5]); end
      if (o_maxm[5] !== 16'h0080) begin errors++; $display("FAIL mix_maxm got %h want 0080", o_maxm[5]); end
      if (o_maxm[7] !== 16'h0080) begin errors++; $display("FAIL mix_maxm_hold got %h want 0080", o_maxm[7]); end
`endif
   endtask

   task automatic test_saturation;
      logic [W-1:0] exp_sq [0:3];
      exp_sq = '{16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF};
      capture(V_SAT, V_SAT, 1, 8);
      for (int c = 2; c <= 5; c++) begin
         checks += 2;
         if (o_idx[c] !== 2'(c - 2))    begin errors++; $display("FAIL sat_index c%0d got %0d want %0d", c, o_idx[c], c - 2); end
         if (o_sq[c] !== exp_sq[c - 2]) begin errors++; $display("FAIL sat_sq c%0d got %h want %h", c, o_sq[c], exp_sq[c - 2]); end
      end
      checks += 3;
      if (o_vec[4] !== 64'h0000_0000_7FFF_0000) begin errors++; $display("FAIL sat_vec_partial got %h want 000000007fff0000", o_vec[4]); end
      if (o_vec[5] !== 64'h0000_0000_7FFF_7FFF) begin errors++; $display("FAIL sat_vec got %h want 000000007fff7fff", o_vec[5]); end
      if (o_done[5] !== 1'b1) begin errors++; $display("FAIL sat_done got %b want 1", o_done[5]); end
`ifdef ARGMAX_EN
      checks += 2;
      if (o_maxi[5] !== 2'd2)     begin errors++; $display("FAIL sat_maxi got %0d want 2", o_maxi[5]); end
      if (o_maxm[5] !== 16'h7FFF) begin errors++; $display("FAIL sat_maxm got %h want 7fff", o_maxm[5]); end
`endif
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] sat_sq [0:3];
      logic exp_v, exp_d, exp_r;
      logic [W-1:0] exp_s;
      int k;
      sat_sq = '{16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF};
      capture(V_UNI, V_SAT, 10, 12);
      for (int c = 0; c < 12; c++) begin
         exp_v = (c >= 2 && c <= 5) || (c >= 7 && c <= 10);
         exp_d = (c == 5) || (c == 10);
         exp_r = (c == 0) || (c == 5) || (c >= 10);
         checks += 3;
         if (o_valid[c] !== exp_v) begin errors++; $display("FAIL b2b_valid c%0d got %b want %b", c, o_valid[c], exp_v); end
         if (o_done[c] !== exp_d)  begin errors++; $display("FAIL b2b_done c%0d got %b want %b", c, o_done[c], exp_d); end
         if (o_ready[c] !== exp_r) begin errors++; $display("FAIL b2b_ready c%0d got %b want %b", c, o_ready[c], exp_r); end
         if (exp_v) begin
            k     = (c <= 5) ? c - 2 : c - 7;
            exp_s = (c <= 5) ? 16'h0040 : sat_sq[k];
            checks += 2;
            if (o_idx[c] !== 2'(k))  begin errors++; $display("FAIL b2b_index c%0d got %0d want %0d", c, o_idx[c], k); end
            if (o_sq[c] !== exp_s)   begin errors++; $display("FAIL b2b_sq c%0d got %h want %h", c, o_sq[c], exp_s); end
         end
      end
      checks += 2;
      if (o_vec[5] !== 64'h0040_0040_0040_0040)  begin errors++; $display("FAIL b2b_vec1 got %h want 0040004000400040", o_vec[5]); end
      if (o_vec[10] !== 64'h0000_0000_7FFF_7FFF) begin errors++; $display("FAIL b2b_vec2 got %h want 000000007fff7fff", o_vec[10]); end
`ifdef ARGMAX_EN
      checks += 3;
      if (o_maxm[5] !== 16'h0040)  begin errors++; $display("FAIL b2b_maxm1 got %h want 0040", o_maxm[5]); end
      if (o_maxm[6] !== 16'h0000)  begin errors++; $display("FAIL b2b_maxm_clear got %h want 0000", o_maxm[6]); end
      if (o_maxi[10] !== 2'd2)     begin errors++; $display("FAIL b2b_maxi2 got %0d want 2", o_maxi[10]); end
`endif
   endtask

   task automatic test_reset_midop;
      @(negedge clk); start = 1'b1; q_state_in = V_UNI;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks += 2;
      if (mag_valid !== 1'b1)  begin errors++; $display("FAIL rmid_busy_valid got %b want 1", mag_valid); end
      if (mag_index !== 2'd1)  begin errors++; $display("FAIL rmid_busy_index got %0d want 1", mag_index); end
      rst_n = 1'b0;
      #1;
      checks += 6;
      if (ready !== 1'b1)        begin errors++; $display("FAIL rmid_ready got %b want 1", ready); end
      if (mag_valid !== 1'b0)    begin errors++; $display("FAIL rmid_valid got %b want 0", mag_valid); end
      if (done !== 1'b0)         begin errors++; $display("FAIL rmid_done got %b want 0", done); end
      if (mag_sq !== 16'h0)      begin errors++; $display("FAIL rmid_sq got %h want 0000", mag_sq); end
      if (mag_vec_out !== 64'h0) begin errors++; $display("FAIL rmid_vec got %h want 0", mag_vec_out); end
      if (max_mag !== 16'h0)     begin errors++; $display("FAIL rmid_maxm got %h want 0000", max_mag); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || mag_valid !== 1'b0) begin errors++; $display("FAIL rmid_hold c%0d got done=%b valid=%b want 0", c, done, mag_valid); end
      end
      rst_n = 1'b1;
      capture(V_MIX, V_MIX, 1, 8);
      for (int c = 0; c < 8; c++) begin
         checks++;
         if (o_done[c] !== (c == 5)) begin errors++; $display("FAIL rmid_rerun_done c%0d got %b", c, o_done[c]); end
      end
      checks += 2;
      if (o_vec[3] !== 64'h0080_0000_0000_0000) begin errors++; $display("FAIL rmid_rerun_vec_partial got %h want 0080000000000000", o_vec[3]); end
      if (o_sq[2] !== 16'h0080) begin errors++; $display("FAIL rmid_rerun_sq got %h want 0080", o_sq[2]); end
   endtask

   initial begin
      test_reset();
      test_uniform();
      test_mixed_signs();
      test_saturation();
      test_back_to_back();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
